// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states,
// transaction owner and access sizes.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Serializes F-stage fetches and M-stage loads/stores onto one external bus
// port, one transaction at a time, with data side priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    input  logic          flush,
    output logic          mem_stall,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    dbg_state
);

    import mem_arbiter_pkg::*;

    // Bus handshake: bus_req is the address-phase valid and stays high with all
    // bus fields frozen until the cycle bus_addr_ok (ready) is seen; the data
    // phase ends in the single cycle bus_data_ok is high.

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          drop_q, drop_d;
    logic          inst_done_q, inst_done_d;
    logic          data_done_q, data_done_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_wr_q, bus_wr_d;
    logic [1:0]    bus_size_q, bus_size_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;

    logic need_d;
    logic need_i;
    logic txn_done;
    logic inst_keep;
    logic data_keep;

    assign need_d    = data_req & ~data_done_q;
    assign need_i    = inst_req & ~inst_done_q & ~flush;
    assign mem_stall = need_d | need_i | (state_q != ST_IDLE);

    assign txn_done  = (state_q == ST_DATA) && bus_data_ok;
    // A fetch completing in the flush cycle itself is stale, so it is discarded too.
    assign inst_keep = txn_done && (owner_q == OWN_I) && !drop_q && !flush;
    assign data_keep = txn_done && (owner_q == OWN_D) && !drop_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (need_d) begin
                    state_d     = ST_ADDR;
                    owner_d     = OWN_D;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (need_i) begin
                    state_d    = ST_ADDR;
                    owner_d    = OWN_I;
                    bus_req_d  = 1'b1;
                    bus_wr_d   = 1'b0;
                    bus_size_d = SZ_W;
                    bus_addr_d = inst_addr;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = ST_DATA;
                    bus_req_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        // Only fetches are abandoned on a flush; the M-stage access must commit.
        if (flush && (owner_q == OWN_I) && (state_q != ST_IDLE) && !txn_done) begin
            drop_d = 1'b1;
        end

        if (!mem_stall || flush) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        if (inst_keep) begin
            inst_done_d  = 1'b1;
            inst_rdata_d = bus_rdata;
        end

        if (data_keep) begin
            data_done_d = 1'b1;
            if (!bus_wr_q) begin
                data_rdata_d = bus_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            drop_q       <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_size   = bus_size_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign dbg_state  = state_q;

endmodule
